shift_unit_iter: RTL

Iterative 32-bit barrel-free shifter. It consumes the 5-bit shift amount produced by the shift-amount select mux (register B[4:0], instruction shamt, constant 16, or MDR[4:0]) and the operand selected for shifting. It performs the requested shift one bit per cycle under a start/done handshake, so the control FSM stalls on `busy`. The result feeds the register-file write-data mux.

---
 rtl/shift_unit_iter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/shift_unit_iter.sv
// shift_unit_iter: iterative 32-bit shifter that moves the operand one bit per
// cycle under a start/done handshake, so the control FSM stalls on busy.
//
// Optional feature macro: SHIFT_UNIT_ROTATE_EN
//   defined   -> ROL (100) and ROR (101) are executed.
//   undefined -> 100/101 decode as NOP and no rotate datapath exists.
//
// Ports:
//   clk       in   1   system clock, rising edge
//   reset     in   1   synchronous active-high reset, dominant over start
//   start     in   1   shift request, accepted in IDLE or DONE
//   shift_op  in   3   000 NOP, 001 SLL, 010 SRL, 011 SRA, 100 ROL, 101 ROR,
//                      110/111 NOP
//   shift_n   in   5   shift amount 0..31
//   data_in   in  32   operand to shift
//   data_out  out 32   working/result register
//   busy      out  1   high while shifting
//   done      out  1   one-cycle pulse, data_out final while high

module shift_unit_iter (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  shift_op,
    input  logic [4:0]  shift_n,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        busy,
    output logic        done
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned OP_W   = 3;

    localparam logic [OP_W-1:0] OP_SLL = 3'b001;
    localparam logic [OP_W-1:0] OP_SRL = 3'b010;
    localparam logic [OP_W-1:0] OP_SRA = 3'b011;
`ifdef SHIFT_UNIT_ROTATE_EN
    localparam logic [OP_W-1:0] OP_ROL = 3'b100;
    localparam logic [OP_W-1:0] OP_ROR = 3'b101;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [OP_W-1:0]     op_q;
    logic [CNT_W-1:0]    cnt;

    logic [DATA_W-1:0]   data_nxt;
    logic [OP_W-1:0]     op_nxt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                busy_nxt;
    logic                done_nxt;

    logic                accept;
    logic                op_shifts;
    logic [DATA_W-1:0]   step_val;

    // Opcodes that actually move bits; everything else completes as a NOP.
    function automatic logic is_shift_op(input logic [OP_W-1:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_SLL,
            OP_SRL,
            OP_SRA:  r = 1'b1;
`ifdef SHIFT_UNIT_ROTATE_EN
            OP_ROL,
            OP_ROR:  r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // One-bit step of the captured operation.
    function automatic logic [DATA_W-1:0] shift_step(input logic [OP_W-1:0]   op,
                                                     input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = d;
        case (op)
            OP_SLL:  r = {d[DATA_W-2:0], 1'b0};
            OP_SRL:  r = {1'b0, d[DATA_W-1:1]};
            // Sign fill re-read from the current MSB each step.
            OP_SRA:  r = {d[DATA_W-1], d[DATA_W-1:1]};
`ifdef SHIFT_UNIT_ROTATE_EN
            OP_ROL:  r = {d[DATA_W-2:0], d[DATA_W-1]};
            OP_ROR:  r = {d[0], d[DATA_W-1:1]};
`endif
            default: r = d;
        endcase
        return r;
    endfunction

    assign accept    = start && (state != ST_SHIFT);
    assign op_shifts = is_shift_op(shift_op) && (shift_n != CNT_W'(0));
    assign step_val  = shift_step(op_q, data_out);

    // State and registered datapath/outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            data_out <= '0;
            op_q     <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            data_out <= data_nxt;
            op_q     <= op_nxt;
            cnt      <= cnt_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

    // Next-state logic; start during SHIFT is ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = op_shifts ? ST_SHIFT : ST_DONE;
            end
            ST_SHIFT: begin
                if (cnt == CNT_W'(1)) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (accept) state_nxt = op_shifts ? ST_SHIFT : ST_DONE;
                else        state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and output next values; busy/done registered from next state.
    always_comb begin
        data_nxt = data_out;
        op_nxt   = op_q;
        cnt_nxt  = cnt;
        busy_nxt = (state_nxt == ST_SHIFT);
        done_nxt = (state_nxt == ST_DONE);
        if (accept) begin
            data_nxt = data_in;
            op_nxt   = shift_op;
            cnt_nxt  = shift_n;
        end else if (state == ST_SHIFT) begin
            data_nxt = step_val;
            cnt_nxt  = cnt - CNT_W'(1);
        end
    end

endmodule
